// File: rtl/valu_wb_pkg.sv
// Shared types and default sizing for the vector ALU result writeback path.
// Latency: n/a (type and constant definitions only).
// Backpressure: n/a.
package valu_wb_pkg;

    localparam int DEF_DATA_WIDTH    = 8;
    localparam int DEF_LANES         = 8;
    localparam int DEF_SELECTOR_SIZE = 4;
    localparam int DEF_REG_ADDR_W    = 4;
    localparam int DEF_DEPTH         = 4;
    localparam int DEF_ZERO_REG      = 1;

    // One full vector of lane results at the default sizing
    typedef logic [DEF_LANES-1:0][DEF_DATA_WIDTH-1:0] lane_vec_t;

    // One pending register-file write at the default sizing
    typedef struct packed {
        lane_vec_t                   data;
        logic [DEF_REG_ADDR_W-1:0]   rd;
        logic [DEF_SELECTOR_SIZE-1:0] selector;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo_ctrl.sv
// Read/write pointers and occupancy count for a power-of-two circular buffer.
// Latency: pointer and count updates take effect at the next clock edge.
// Backpressure: caller must not push when full or pop when empty; flush overrides both.
module wb_fifo_ctrl #(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_flush,
    output logic [PTR_W-1:0] o_wr_ptr,
    output logic [PTR_W-1:0] o_rd_ptr,
    output logic [CNT_W-1:0] o_count,
    output logic             o_full,
    output logic             o_empty
);

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    // Advance pointers (natural power-of-two wrap) and track occupancy; flush wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_wr_ptr = r_wr_ptr;
    assign o_rd_ptr = r_rd_ptr;
    assign o_count  = r_count;
    assign o_full   = (r_count == CNT_W'(DEPTH));
    assign o_empty  = (r_count == '0);

endmodule

// File: rtl/valu_result_writeback.sv
// Buffers vector ALU results in order and drains them into the register-file write port (bypass lookup under VALU_WB_BYPASS_EN).
// Latency: a result accepted at edge N is presented on wr_en in cycle N+1; one write per cycle.
// Backpressure: in_ready drops only when all DEPTH entries are occupied; wr_ready low holds the head.
module valu_result_writeback
    import valu_wb_pkg::*;
#(
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int LANES         = DEF_LANES,
    parameter int SELECTOR_SIZE = DEF_SELECTOR_SIZE,
    parameter int REG_ADDR_W    = DEF_REG_ADDR_W,
    parameter int DEPTH         = DEF_DEPTH,
    parameter int ZERO_REG      = DEF_ZERO_REG
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [LANES-1:0][DATA_WIDTH-1:0]  in_data,
    input  logic [REG_ADDR_W-1:0]             in_rd,
    input  logic [SELECTOR_SIZE-1:0]          in_selector,
    input  logic                              in_wb_en,
    input  logic                              flush,
    output logic                              wr_en,
    input  logic                              wr_ready,
    output logic [REG_ADDR_W-1:0]             wr_addr,
    output logic [LANES-1:0][DATA_WIDTH-1:0]  wr_data,
    output logic [SELECTOR_SIZE-1:0]          wr_selector,
    output logic [$clog2(DEPTH):0]            count,
    input  logic [REG_ADDR_W-1:0]             byp_addr,
    output logic                              byp_hit,
    output logic [LANES-1:0][DATA_WIDTH-1:0]  byp_data
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [LANES-1:0][DATA_WIDTH-1:0] data;
        logic [REG_ADDR_W-1:0]            rd;
        logic [SELECTOR_SIZE-1:0]         selector;
    } entry_t;

    entry_t           r_mem [DEPTH];
    entry_t           w_head;
    logic [PTR_W-1:0] w_wr_ptr;
    logic [PTR_W-1:0] w_rd_ptr;
    logic [CNT_W-1:0] w_count;
    logic             w_full;
    logic             w_empty;
    logic             w_accept;
    logic             w_keep;
    logic             w_push;
    logic             w_pop;

    // A handshake always completes when there is room; only useful results take a slot
    assign w_accept = in_valid & in_ready;
    assign w_keep   = in_wb_en & ~((ZERO_REG != 0) & (in_rd == '0));
    assign w_push   = w_accept & w_keep & ~flush;
    assign w_pop    = wr_en & wr_ready;

    wb_fifo_ctrl #(
        .DEPTH (DEPTH)
    ) u_ctrl (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_push   (w_push),
        .i_pop    (w_pop),
        .i_flush  (flush),
        .o_wr_ptr (w_wr_ptr),
        .o_rd_ptr (w_rd_ptr),
        .o_count  (w_count),
        .o_full   (w_full),
        .o_empty  (w_empty)
    );

    // Entry storage: written at the tail on push, fully cleared on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[w_wr_ptr] <= '{data: in_data, rd: in_rd, selector: in_selector};
        end
    end

    // Ready is independent of a same-cycle pop, so a full buffer never passes through
    assign in_ready = ~w_full;
    assign count    = w_count;

    // Head is read straight from storage; stale slots are masked to zero when empty
    assign w_head      = r_mem[w_rd_ptr];
    assign wr_en       = ~w_empty;
    assign wr_addr     = w_empty ? '0 : w_head.rd;
    assign wr_data     = w_empty ? '0 : w_head.data;
    assign wr_selector = w_empty ? '0 : w_head.selector;

`ifdef VALU_WB_BYPASS_EN
    logic [PTR_W-1:0] w_byp_idx;

    // Walk occupied slots oldest to youngest so the youngest match is the one left standing
    always_comb begin
        byp_hit   = 1'b0;
        byp_data  = '0;
        w_byp_idx = w_rd_ptr;
        for (int i = 0; i < DEPTH; i++) begin
            w_byp_idx = w_rd_ptr + PTR_W'(i);
            if ((CNT_W'(i) < w_count) && (r_mem[w_byp_idx].rd == byp_addr)) begin
                byp_hit  = 1'b1;
                byp_data = r_mem[w_byp_idx].data;
            end
        end
    end
`else
    logic w_unused_byp;

    assign byp_hit      = 1'b0;
    assign byp_data     = '0;
    assign w_unused_byp = ^byp_addr;
`endif

endmodule

// File: tb/tb_valu_result_writeback.sv
module tb_valu_result_writeback;

    localparam int DW    = 8;
    localparam int LN    = 8;
    localparam int SW    = 4;
    localparam int AW    = 4;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic                  clk;
    logic                  rst_n;
    logic                  in_valid;
    logic                  in_ready;
    logic [LN-1:0][DW-1:0] in_data;
    logic [AW-1:0]         in_rd;
    logic [SW-1:0]         in_selector;
    logic                  in_wb_en;
    logic                  flush;
    logic                  wr_en;
    logic                  wr_ready;
    logic [AW-1:0]         wr_addr;
    logic [LN-1:0][DW-1:0] wr_data;
    logic [SW-1:0]         wr_selector;
    logic [CW-1:0]         count;
    logic [AW-1:0]         byp_addr;
    logic                  byp_hit;
    logic [LN-1:0][DW-1:0] byp_data;

    typedef struct {
        logic [AW-1:0] rd;
        logic [63:0]   data;
        logic [SW-1:0] sel;
    } ent_t;

    // Reference model: the list of results the register file still owes a write
    ent_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    bit   mon_en = 1'b0;

    valu_result_writeback #(
        .DATA_WIDTH    (DW),
        .LANES         (LN),
        .SELECTOR_SIZE (SW),
        .REG_ADDR_W    (AW),
        .DEPTH         (DEPTH),
        .ZERO_REG      (1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_rd       (in_rd),
        .in_selector (in_selector),
        .in_wb_en    (in_wb_en),
        .flush       (flush),
        .wr_en       (wr_en),
        .wr_ready    (wr_ready),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_selector (wr_selector),
        .count       (count),
        .byp_addr    (byp_addr),
        .byp_hit     (byp_hit),
        .byp_data    (byp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: compares DUT outputs with the model every cycle and retires written entries
    always @(negedge clk) begin
        int          n;
        logic        hit;
        logic [63:0] bd;
        if (mon_en) begin
            n = exp_q.size();
            chk("in_ready", 64'(in_ready), 64'(n < DEPTH));
            chk("count", 64'(count), 64'(n));
            chk("wr_en", 64'(wr_en), 64'(n != 0));
            if (n != 0) begin
                chk("wr_addr", 64'(wr_addr), 64'(exp_q[0].rd));
                chk("wr_data", 64'(wr_data), exp_q[0].data);
                chk("wr_selector", 64'(wr_selector), 64'(exp_q[0].sel));
            end else begin
                chk("idle_addr", 64'(wr_addr), 64'd0);
                chk("idle_data", 64'(wr_data), 64'd0);
                chk("idle_selector", 64'(wr_selector), 64'd0);
            end
            hit = 1'b0;
            bd  = 64'd0;
`ifdef VALU_WB_BYPASS_EN
            foreach (exp_q[i]) begin
                if (exp_q[i].rd == byp_addr) begin
                    hit = 1'b1;
                    bd  = exp_q[i].data;
                end
            end
`endif
            chk("byp_hit", 64'(byp_hit), 64'(hit));
            chk("byp_data", 64'(byp_data), bd);
            if ((n != 0) && wr_ready) begin
                void'(exp_q.pop_front());
            end
        end
    end

    // Drive one cycle of stimulus and record the expected effect at the edge
    task automatic step(input bit v, input logic [AW-1:0] rd, input logic [63:0] d,
                        input logic [SW-1:0] sel, input bit wben, input bit fl,
                        input bit wrr, input logic [AW-1:0] ba);
        bit   push;
        ent_t e;
        in_valid    = v;
        in_rd       = rd;
        in_data     = d;
        in_selector = sel;
        in_wb_en    = wben;
        flush       = fl;
        wr_ready    = wrr;
        byp_addr    = ba;
        push  = v && (exp_q.size() < DEPTH) && wben && (rd != 0) && !fl;
        e.rd   = rd;
        e.data = d;
        e.sel  = sel;
        @(posedge clk);
        if (fl) begin
            exp_q.delete();
        end else if (push) begin
            exp_q.push_back(e);
        end
        #1;
    endtask

    task automatic idle(input int n, input bit wrr);
        for (int k = 0; k < n; k++) begin
            step(1'b0, 4'd0, 64'd0, 4'd0, 1'b0, 1'b0, wrr, 4'd0);
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_rd       = '0;
        in_data     = '0;
        in_selector = '0;
        in_wb_en    = 1'b0;
        flush       = 1'b0;
        wr_ready    = 1'b0;
        byp_addr    = '0;

        #12;
        chk("rst_wr_en", 64'(wr_en), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_wr_addr", 64'(wr_addr), 64'd0);
        chk("rst_wr_data", 64'(wr_data), 64'd0);
        chk("rst_wr_selector", 64'(wr_selector), 64'd0);
        chk("rst_byp_hit", 64'(byp_hit), 64'd0);
        chk("rst_byp_data", 64'(byp_data), 64'd0);
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Single result, register file ready
        step(1'b1, 4'd3, 64'h0807060504030201, 4'h2, 1'b1, 1'b0, 1'b1, 4'd3);
        idle(3, 1'b1);

        // Fill while stalled, attempt a fifth, then drain in order
        for (int r = 1; r <= 4; r++) begin
            step(1'b1, 4'(r), {8{8'(r * 17)}}, 4'(r), 1'b1, 1'b0, 1'b0, 4'(r));
        end
        step(1'b1, 4'd5, {8{8'h55}}, 4'd5, 1'b1, 1'b0, 1'b0, 4'd5);
        idle(6, 1'b1);

        // Dropped results: write-back disabled, and register zero
        step(1'b1, 4'd7, {8{8'h77}}, 4'd1, 1'b0, 1'b0, 1'b1, 4'd7);
        step(1'b1, 4'd0, {8{8'h99}}, 4'd1, 1'b1, 1'b0, 1'b1, 4'd0);
        idle(2, 1'b1);

        // Concurrent push and pop at count 2, then a run that wraps the pointers
        step(1'b1, 4'd1, 64'h1111, 4'd1, 1'b1, 1'b0, 1'b0, 4'd0);
        step(1'b1, 4'd2, 64'h2222, 4'd2, 1'b1, 1'b0, 1'b0, 4'd0);
        for (int k = 0; k < 10; k++) begin
            step(1'b1, 4'(k % 7 + 1), 64'({$urandom, $urandom}), 4'(k), 1'b1, 1'b0, 1'b1, 4'(k));
        end
        idle(4, 1'b1);

        // Flush at count 3 with a simultaneous push
        for (int r = 1; r <= 3; r++) begin
            step(1'b1, 4'(r + 8), {8{8'(r)}}, 4'(r), 1'b1, 1'b0, 1'b0, 4'd9);
        end
        step(1'b1, 4'd12, {8{8'hCC}}, 4'd3, 1'b1, 1'b1, 1'b0, 4'd12);
        idle(2, 1'b1);

        // Two pending writes to the same register for the bypass lookup
        step(1'b1, 4'd5, {8{8'hAA}}, 4'd1, 1'b1, 1'b0, 1'b0, 4'd5);
        step(1'b1, 4'd5, {8{8'hBB}}, 4'd2, 1'b1, 1'b0, 1'b0, 4'd5);
        step(1'b0, 4'd0, 64'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd5);
        step(1'b0, 4'd0, 64'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd6);
        step(1'b0, 4'd0, 64'd0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd5);
        idle(2, 1'b1);

        // Randomized traffic
        for (int k = 0; k < 1500; k++) begin
            step(($urandom % 4) != 0,
                 4'($urandom_range(0, 7)),
                 64'({$urandom, $urandom}),
                 4'($urandom_range(0, 15)),
                 ($urandom % 8) != 0,
                 ($urandom % 32) == 0,
                 ($urandom % 4) != 0,
                 4'($urandom_range(0, 7)));
        end

        // Reset in the middle of a drain
        for (int r = 1; r <= 3; r++) begin
            step(1'b1, 4'(r), {8{8'(r + 64)}}, 4'(r), 1'b1, 1'b0, 1'b0, 4'(r));
        end
        step(1'b0, 4'd0, 64'd0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd2);
        mon_en   = 1'b0;
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_count", 64'(count), 64'd0);
        chk("midrst_wr_en", 64'(wr_en), 64'd0);
        chk("midrst_wr_data", 64'(wr_data), 64'd0);
        chk("midrst_byp_hit", 64'(byp_hit), 64'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;

        for (int k = 0; k < 60; k++) begin
            step(($urandom % 2) != 0,
                 4'($urandom_range(0, 7)),
                 64'({$urandom, $urandom}),
                 4'($urandom_range(0, 15)),
                 1'b1,
                 1'b0,
                 ($urandom % 2) != 0,
                 4'($urandom_range(0, 7)));
        end
        idle(8, 1'b1);

        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/valu_result_writeback.md
Name: valu_result_writeback

Overview:
- Consumer end of the vector ALU datapath. It accepts per-instruction ALU results (all lanes, destination register, selector) over a valid/ready handshake.
- Results are held in a small in-order FIFO and drained one per cycle into the vector register file write port, which supplies its own ready.
- Decouples ALU issue from register-file write stalls.

Parameters:
- DATA_WIDTH, 8, bits per lane
- LANES, 8, lanes per vector
- SELECTOR_SIZE, 4, ALU selector width carried with each result
- REG_ADDR_W, 4, vector register address width
- DEPTH, 4, FIFO entries; power of two, at least 2
- ZERO_REG, 1, when 1, results targeting register 0 are discarded

Ports:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- in_valid  in  1  result valid
- in_ready  out  1  block can accept a result
- in_data  in  [LANES-1:0][DATA_WIDTH-1:0]  ALU lane results
- in_rd  in  REG_ADDR_W  destination vector register
- in_selector  in  SELECTOR_SIZE  ALU op code that produced the result
- in_wb_en  in  1  result must be written back
- flush  in  1  synchronous discard of all pending entries
- wr_en  out  1  register-file write request
- wr_ready  in  1  register file accepts the write this cycle
- wr_addr  out  REG_ADDR_W  write address
- wr_data  out  [LANES-1:0][DATA_WIDTH-1:0]  write data
- wr_selector  out  SELECTOR_SIZE  selector of the head entry (debug/trace)
- count  out  $clog2(DEPTH)+1  occupied entries
- byp_addr  in  REG_ADDR_W  bypass lookup address
- byp_hit  out  1  a pending entry targets byp_addr
- byp_data  out  [LANES-1:0][DATA_WIDTH-1:0]  data of the youngest matching entry

Behaviour:
- Reset (async, rst_n=0):
  - pointers and count are 0; all storage is cleared to 0.
  - wr_en=0, wr_addr=0, wr_data=0, wr_selector=0, byp_hit=0, byp_data=0; in_ready=1 after release.
- in_ready = (count < DEPTH). It does not depend on pop in the same cycle, so there is no full-FIFO pass-through.
- Push condition: in_valid & in_ready & in_wb_en & !(ZERO_REG & in_rd==0) & !flush.
  - A handshake where in_wb_en=0 or rd==0 (with ZERO_REG=1) is accepted and dropped; count is unchanged.
- Head outputs are driven from registered storage: wr_en = (count!=0); wr_addr/wr_data/wr_selector come from the head entry.
  - When empty, these outputs hold 0.
- Pop on wr_en & wr_ready. The head advances and the next entry is presented the following cycle.
- Latency: a result accepted at edge N appears on wr_en after edge N, i.e. in cycle N+1 at the earliest. Throughput is 1 write/cycle.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH. count spans 0..DEPTH.
- Order is strictly in order. Entries to the same register are written oldest first.
- wr_ready held low: the head is stable and outputs are unchanged (wr_en stays high).
- flush=1: next edge sets count=0 and pointers=0.
  - flush has priority over push and pop in the same cycle; a concurrent wr_en&wr_ready write is still considered performed by the register file.
- Reset asserted mid-drain aborts immediately; no partial state is retained.

Optional Feature:
- Macro VALU_WB_BYPASS_EN.
- Defined:
  - byp_hit=1 when any occupied entry has rd==byp_addr (combinational).
  - byp_data is the youngest matching entry, so the newest write wins; 0 when there is no hit.
  - An entry popping this cycle still counts as a hit.
- Undefined: byp_hit and byp_data are tied to 0; no comparators are synthesized. Ports remain present.

Decomposition:
- Package valu_wb_pkg:
  - lane_vec_t typedef (packed LANES×DATA_WIDTH)
  - wb_entry_t struct {data, rd, selector}
  - default parameter constants
- Sub-module wb_fifo_ctrl: pointer, count, full/empty and wrap logic, parameterized by DEPTH.
- Storage, drop filter and bypass search stay in the top module.

Test Plan:
- Reset, then push rd=3 data lanes 0x01..0x08 with wr_ready=1 -> wr_en high the next cycle with wr_addr=3 and matching data; count returns to 0 after the pop.
- wr_ready=0, push 4 results rd=1..4 -> count=4 and in_ready=0. A 5th in_valid is not accepted. Raise wr_ready -> writes rd 1,2,3,4 in order on consecutive cycles.
- Push with in_wb_en=0, then push rd=0 with ZERO_REG=1 -> both handshakes complete, count stays 0, wr_en never asserts.
- Count=2 with push+pop in the same cycle -> count stays 2, then rd order is preserved; run 10 pushes to exercise pointer wrap across DEPTH=4.
- Count=3 with flush=1 and in_valid=1 in the same cycle -> count=0 and wr_en=0 next cycle; the pushed entry is absent.
- VALU_WB_BYPASS_EN: pending rd=5 data 0xAA.. then rd=5 data 0xBB.., byp_addr=5 -> byp_hit=1 and byp_data=0xBB..; byp_addr=6 -> hit=0, data=0.
